peribus_arbiter: RTL and testbench

Round-robin arbiter that shares the single peripheral bus (8-bit address, 16-bit data, write/read enables) between several bus masters, e.g. the memory unit's CPU port and a DMA/boot-loader master. It sits between the masters and the peripheral bus controller. It serialises accesses into fixed three-state transactions and returns read data with a one-cycle acknowledge per master.

---
 rtl/peribus_pkg.sv | 15 +
 rtl/peribus_arbiter_rr_picker.sv | 32 +++
 rtl/peribus_arbiter.sv | 111 +++++++++++
 tb/tb_peribus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peribus_pkg.sv
// Shared types and defaults for the peripheral bus arbiter.
package peribus_pkg;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int MAX_REQ        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Wide enough for any supported master count.
  typedef logic [$clog2(MAX_REQ)-1:0] grant_idx_t;
endpackage

// File: rtl/peribus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: scans masters starting just after
// last_grant, optionally skipping the master named by mask_idx.
module rr_picker
  import peribus_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  input  logic                       mask_en,
  input  logic [$clog2(NUM_REQ)-1:0] mask_idx,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IW = $clog2(NUM_REQ);

  grant_idx_t cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Offset NUM_REQ lands back on last_grant, so it has lowest priority.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = grant_idx_t'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req[cand[IW-1:0]] && !(mask_en && cand[IW-1:0] == mask_idx)) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/peribus_arbiter.sv
// Round-robin arbiter serialising master accesses onto the peripheral bus as
// IDLE -> ADDR -> ACK transactions, with back-to-back ADDR from ACK.
module peribus_arbiter
  import peribus_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          peribus_clock,
  input  logic                          reset_bar,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         bus_addr,
  output logic [DATA_WIDTH-1:0]         bus_wdata,
  output logic                          bus_write_enable,
  output logic                          bus_read_enable,
  input  logic [DATA_WIDTH-1:0]         bus_rdata
);
  localparam int IW = $clog2(NUM_REQ);

  state_t state, state_next;
  logic [IW-1:0] last_grant, arb_last, pick_idx;
  logic          arb_mask, pick_found, load;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // In ACK the current grantee becomes last_grant and its req is ignored.
  assign arb_last = (state == ACK) ? grant_id : last_grant;
  assign arb_mask = (state == ACK);

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req),
    .last_grant (arb_last),
    .mask_en    (arb_mask),
    .mask_idx   (grant_id),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  always_ff @(posedge peribus_clock or negedge reset_bar) begin
    if (!reset_bar) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: if (pick_found) begin
        load       = 1'b1;
        state_next = ADDR;
      end
      ADDR: state_next = ACK;
      ACK: begin
        if (pick_found) begin
          load       = 1'b1;
          state_next = ADDR;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state == ACK) ack[grant_id] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Enables are registered alongside the latched address so they line up with ADDR.
  always_ff @(posedge peribus_clock or negedge reset_bar) begin
    if (!reset_bar) begin
      last_grant       <= IW'(NUM_REQ - 1);
      grant_id         <= '0;
      rdata            <= '0;
      bus_addr         <= '0;
      bus_wdata        <= '0;
      bus_write_enable <= 1'b0;
      bus_read_enable  <= 1'b0;
    end else begin
      bus_write_enable <= 1'b0;
      bus_read_enable  <= load;
      if (load) begin
        grant_id         <= pick_idx;
        bus_addr         <= addr_arr[pick_idx];
        bus_wdata        <= wdata_arr[pick_idx];
        bus_write_enable <= req_we[pick_idx];
      end
      if (state == ADDR && !bus_write_enable) rdata <= bus_rdata;
      if (state == ACK) last_grant <= grant_id;
    end
  end
endmodule

// File: tb/tb_peribus_arbiter.sv
// Bench for peribus_arbiter: directed scenarios plus random traffic, all
// checked by a transaction-level round-robin model and queue scoreboard.
module tb_peribus_arbiter;
  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic [IW-1:0] id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;
  localparam int TW = $bits(txn_t);

  logic          clk = 1'b0;
  logic          reset_bar;
  logic [N-1:0]    req = '0, req_we = '0, ack;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rdata, bus_wdata, bus_rdata = '0;
  logic [IW-1:0] grant_id;
  logic          busy, bus_write_enable, bus_read_enable;
  logic [AW-1:0] bus_addr;

  int n_checks = 0;
  int n_errors = 0;
  int we_cycles = 0;

  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] bus_q[$];

  peribus_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .peribus_clock    (clk),
    .reset_bar        (reset_bar),
    .req              (req),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .ack              (ack),
    .rdata            (rdata),
    .grant_id         (grant_id),
    .busy             (busy),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_rdata        (bus_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: the next master after the last winner that is requesting,
  // never the one excluded.
  function automatic int rr_winner(input logic [N-1:0] r, input int last, input int excl);
    for (int k = 1; k <= N; k++) begin
      int c = (last + k) % N;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  int   m_phase = 0;  // 0: free to arbitrate, 1: bus cycle ending, 2: ack cycle ending
  int   m_last  = N - 1;
  logic [DW-1:0] m_rdata = '0;
  txn_t m_cur = '0;

  function automatic txn_t grab(input int w);
    txn_t t;
    t.id    = IW'(w);
    t.we    = req_we[w];
    t.addr  = req_addr[w*AW +: AW];
    t.wdata = req_wdata[w*DW +: DW];
    t.rdata = '0;
    return t;
  endfunction

  always @(posedge clk or negedge reset_bar) begin
    int w;
    if (!reset_bar) begin
      m_phase = 0;
      m_last  = N - 1;
      m_rdata = '0;
      exp_q.delete();
      bus_q.delete();
    end else begin
      case (m_phase)
        0: begin
          w = rr_winner(req, m_last, -1);
          if (w >= 0) begin
            m_cur = grab(w);
            bus_q.push_back(m_cur);
            m_phase = 1;
          end
        end
        1: begin
          if (!m_cur.we) m_rdata = bus_rdata;
          m_cur.rdata = m_rdata;
          exp_q.push_back(m_cur);
          m_phase = 2;
        end
        default: begin
          m_last = int'(m_cur.id);
          w = rr_winner(req, m_last, m_last);
          if (w >= 0) begin
            m_cur = grab(w);
            bus_q.push_back(m_cur);
            m_phase = 1;
          end else begin
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT drives a bus cycle or an ack.
  always @(negedge clk) begin
    txn_t t;
    if (reset_bar === 1'b1) begin
      if (bus_write_enable) we_cycles++;
      if (bus_read_enable) begin
        if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
        else begin
          t = txn_t'(bus_q.pop_front());
          check("bus_addr", bus_addr, t.addr);
          check("bus_wdata", bus_wdata, t.wdata);
          check("bus_we", bus_write_enable, t.we);
          check("bus_grant_id", grant_id, t.id);
          check("bus_busy", busy, 1);
        end
      end else begin
        check("we_outside_addr", bus_write_enable, 0);
      end
      if (ack != '0) begin
        if (exp_q.size() == 0) check("ack_unexpected", ack, 0);
        else begin
          t = txn_t'(exp_q.pop_front());
          check("ack_onehot", ack, 32'(1) << t.id);
          check("ack_grant_id", grant_id, t.id);
          check("ack_rdata", rdata, t.rdata);
          check("ack_busy", busy, 1);
        end
      end
    end
  end

  // Driver tasks
  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]              = 1'b1;
    req_we[i]           = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input bit drop, output int id, output int cyc);
    id  = -1;
    cyc = 0;
    while (id < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++)
        if (ack[i]) begin
          id = i;
          if (drop) req[i] = 1'b0;
        end
    end
    if (id < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_timeout: got none expected ack within 20 cycles");
    end
  endtask

  initial begin
    int id, cyc, we0, n_ack;
    int ids[8];
    int tms[8];

    // Reset
    reset_bar = 1'b0;
    idle(2);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_we", bus_write_enable, 0);
    check("rst_re", bus_read_enable, 0);
    reset_bar = 1'b1;
    idle(1);

    // Single write from master 0
    we0 = we_cycles;
    set_req(0, 1'b1, 8'h10, 16'hBEEF);
    wait_ack(1'b1, id, cyc);
    check("wr_id", id, 0);
    check("wr_latency", cyc, 2);
    idle(2);
    check("wr_strobe_cycles", we_cycles - we0, 1);

    // Single read from master 1
    we0 = we_cycles;
    bus_rdata = 16'h1234;
    set_req(1, 1'b0, 8'h04, 16'h0000);
    wait_ack(1'b1, id, cyc);
    check("rd_id", id, 1);
    check("rd_rdata", rdata, 16'h1234);
    idle(2);
    check("rd_no_strobe", we_cycles - we0, 0);

    // Contention: both masters request continuously
    set_req(0, 1'b0, 8'h20, 16'h0);
    set_req(1, 1'b1, 8'h21, 16'h5A5A);
    cyc = 0;
    n_ack = 0;
    while (n_ack < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus_rdata = 16'($urandom);
      for (int i = 0; i < N; i++)
        if (ack[i] && n_ack < 8) begin
          ids[n_ack] = i;
          tms[n_ack] = cyc;
          n_ack++;
        end
    end
    req = '0;
    check("cont_count", n_ack, 8);
    for (int j = 0; j < n_ack; j++) begin
      check("cont_order", ids[j], j % 2);
      if (j > 0) check("cont_gap", tms[j] - tms[j-1], 2);
    end
    idle(2);

    // Held req: master 0 keeps req one cycle past its ack
    set_req(0, 1'b0, 8'h30, 16'h0);
    wait_ack(1'b0, id, cyc);
    check("hold_first_id", id, 0);
    @(negedge clk);
    check("hold_idle_busy", busy, 0);
    wait_ack(1'b1, id, cyc);
    check("hold_second_id", id, 0);
    check("hold_second_latency", cyc, 2);
    idle(2);

    // Withdrawn req: master 1 drops req during its bus cycle
    set_req(1, 1'b0, 8'h44, 16'h0);
    @(negedge clk);
    check("wd_in_addr", bus_read_enable, 1);
    req[1] = 1'b0;
    wait_ack(1'b0, id, cyc);
    check("wd_id", id, 1);
    check("wd_latency", cyc, 1);
    idle(2);

    // Reset in the middle of a write
    set_req(1, 1'b1, 8'h55, 16'hCAFE);
    @(negedge clk);
    check("mid_we_before", bus_write_enable, 1);
    #2 reset_bar = 1'b0;
    #1;
    check("mid_we_cut", bus_write_enable, 0);
    check("mid_re_cut", bus_read_enable, 0);
    check("mid_busy", busy, 0);
    check("mid_ack", ack, 0);
    req = '0;
    idle(2);
    reset_bar = 1'b1;
    set_req(0, 1'b0, 8'h60, 16'h0);
    set_req(1, 1'b0, 8'h61, 16'h0);
    wait_ack(1'b1, id, cyc);
    check("post_rst_first", id, 0);
    wait_ack(1'b1, id, cyc);
    check("post_rst_second", id, 1);
    check("post_rst_gap", cyc, 2);
    idle(2);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus_rdata = 16'($urandom);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(3) == 0)
            set_req(i, 1'($urandom), 8'($urandom), 16'($urandom));
          else
            req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0)
            set_req(i, 1'($urandom), 8'($urandom), 16'($urandom));
        end else if ($urandom_range(31) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    idle(6);
    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_bus_q_empty", bus_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
